// File: rtl/op_arbiter_if.sv
// op_arbiter_if: request, shared-unit and response signals of op_arbiter.
// master is the arbiter side; slave is its environment.
interface op_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   logic              en;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      unit_x;
   logic [W-1:0]      unit_y;
   logic [W-1:0]      unit_z;
   logic              resp_valid;
   logic              resp_ready;
   logic [W-1:0]      resp_data;
   logic [2:0]        resp_id;
   logic              busy;
   logic [7:0]        done_cnt;

   modport master (
      input  en, req_valid, req_a, req_b, unit_z, resp_ready,
      output req_ready, unit_x, unit_y, resp_valid, resp_data,
      output resp_id, busy, done_cnt
   );

   modport slave (
      output en, req_valid, req_a, req_b, unit_z, resp_ready,
      input  req_ready, unit_x, unit_y, resp_valid, resp_data,
      input  resp_id, busy, done_cnt
   );
endinterface

// File: rtl/op_arbiter.sv
// op_arbiter: round-robin arbiter sharing one combinational unit among
// NREQ requesters, with an LAT-deep stallable result pipeline.
module op_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int LAT  = 2
) (
   input logic          clk,
   input logic          rst,
   op_arbiter_if.master bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   idx;
   logic            any;
   logic            stall;
   logic            grant;
   logic [LAT-1:0]  vld;
   logic [LAT-1:0]  vld_nxt;
   logic [W-1:0]    data [LAT];
   logic [2:0]      id   [LAT];
   logic [7:0]      cnt;

   // Walk downward so the nearest valid requester above ptr wins last.
   always_comb begin
      win = ptr;
      idx = ptr;
      any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end

   assign stall = vld[LAT-1] & ~bus.resp_ready;
   assign grant = (state == RUN) && !stall && any;

   always_comb begin
      bus.req_ready = '0;
      bus.unit_x    = '0;
      bus.unit_y    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant && win == PW'(i)) begin
            bus.req_ready[i] = 1'b1;
            bus.unit_x       = bus.req_a[i*W +: W];
            bus.unit_y       = bus.req_b[i*W +: W];
         end
      end
   end

   // Bubbles advance like results, so nothing ever compresses.
   always_comb begin
      vld_nxt = vld;
      if (!stall) begin
         vld_nxt[0] = grant;
         for (int s = 1; s < LAT; s++) begin
            vld_nxt[s] = vld[s-1];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.en) state_nxt = RUN;
         end
         RUN: begin
            if (!bus.en) state_nxt = (|vld_nxt) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (bus.en)         state_nxt = RUN;
            else if (~|vld_nxt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         vld   <= '0;
         cnt   <= '0;
         for (int s = 0; s < LAT; s++) begin
            data[s] <= '0;
            id[s]   <= '0;
         end
      end else begin
         state <= state_nxt;
         vld   <= vld_nxt;
         if (grant) begin
            ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
         end
         if (!stall) begin
            data[0] <= grant ? bus.unit_z : '0;
            id[0]   <= grant ? 3'(win) : 3'd0;
            for (int s = 1; s < LAT; s++) begin
               data[s] <= data[s-1];
               id[s]   <= id[s-1];
            end
         end
         if (bus.resp_valid && bus.resp_ready) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   assign bus.resp_valid = vld[LAT-1];
   assign bus.resp_data  = data[LAT-1];
   assign bus.resp_id    = id[LAT-1];
   assign bus.busy       = (state != IDLE) || (|vld);
   assign bus.done_cnt   = cnt;
endmodule
